// File: rtl/video_in_framer.sv
// video_in_framer: frame-aligns an AXI4-Stream video input, checks line/frame
// geometry, flags errors and forwards pixels through a 2-entry output FIFO.
module video_in_framer #(
  parameter int unsigned LINE_PIXELS = 640,
  parameter int unsigned FRAME_LINES = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  input  logic        enable,
  input  logic        err_clr,
  output logic [2:0]  err,
  output logic [15:0] frame_count
);

  localparam int unsigned PIX_W  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int unsigned LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(LINE_PIXELS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(FRAME_LINES - 1);

  typedef struct packed {
    logic [23:0] data;
    logic        user;
    logic        last;
  } beat_t;

  typedef enum logic {WAIT_SOF = 1'b0, PASS = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pix_q, pix_d, cur_pix;
  logic [LINE_W-1:0]  line_q, line_d, cur_line;
  logic [2:0]         err_q, err_d, err_set;
  logic [15:0]        fc_q;
  logic               fc_inc;
  logic               s_tready_q, s_tready_d, rst_dly_q;
  beat_t              head_q, head_d, skid_q, skid_d, beat_in;
  logic               head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic               acc, start, restart, at_sol, fwd, eol, eof, pop;

  // Classify the beat on the input: accepted, forwarded, position in the frame
  always_comb begin
    acc      = s_tvalid && s_tready_q;
    start    = (state_q == WAIT_SOF) && s_tuser && enable;
    restart  = (state_q == PASS) && s_tuser;
    at_sol   = start || restart;
    fwd      = acc && ((state_q == PASS) || start);
    cur_pix  = at_sol ? '0 : pix_q;
    cur_line = at_sol ? '0 : line_q;
    eol      = (cur_pix == LAST_PIX);
    eof      = (cur_line == LAST_LINE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT_SOF;
    else       state_q <= state_d;
  end

  // Next state: any line termination that is not mid-frame drops back to WAIT_SOF
  always_comb begin
    state_d = state_q;
    if (fwd) begin
      if (eol && (!s_tlast || eof)) state_d = WAIT_SOF;
      else if (!eol && s_tlast)     state_d = WAIT_SOF;
      else                          state_d = PASS;
    end
  end

  // Outputs of the FSM: counters, error events, frame completion, output beat
  always_comb begin
    pix_d   = pix_q;
    line_d  = line_q;
    err_set = '0;
    fc_inc  = 1'b0;
    beat_in = '{data: s_tdata, user: at_sol, last: s_tlast || eol};
    if (fwd) begin
      err_set[2] = restart;
      if (eol) begin
        pix_d  = '0;
        line_d = '0;
        if (!s_tlast)  err_set[1] = 1'b1;
        else if (eof)  fc_inc     = 1'b1;
        else           line_d     = cur_line + LINE_W'(1);
      end else if (s_tlast) begin
        err_set[0] = 1'b1;
        pix_d      = '0;
        line_d     = '0;
      end else begin
        pix_d  = cur_pix + PIX_W'(1);
        line_d = cur_line;
      end
    end
  end

  // Two-entry FIFO: head register drives m_*, skid register holds the second beat
  always_comb begin
    pop        = head_vld_q && m_tready;
    head_d     = head_q;
    head_vld_d = head_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!head_vld_q || pop) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = fwd;
        if (fwd) skid_d = beat_in;
      end else begin
        head_vld_d = fwd;
        if (fwd) head_d = beat_in;
      end
    end else if (fwd) begin
      skid_d     = beat_in;
      skid_vld_d = 1'b1;
    end
    s_tready_d = !rst_dly_q && !(head_vld_d && skid_vld_d);
    err_d      = (err_q & ~{3{err_clr}}) | err_set;
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q      <= '0;
      line_q     <= '0;
      err_q      <= '0;
      fc_q       <= '0;
      head_q     <= '0;
      skid_q     <= '0;
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      s_tready_q <= 1'b0;
      rst_dly_q  <= 1'b1;
    end else begin
      pix_q      <= pix_d;
      line_q     <= line_d;
      err_q      <= err_d;
      fc_q       <= fc_q + 16'(fc_inc);
      head_q     <= head_d;
      skid_q     <= skid_d;
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      s_tready_q <= s_tready_d;
      rst_dly_q  <= 1'b0;
    end
  end

  assign s_tready    = s_tready_q;
  assign m_tdata     = head_q.data;
  assign m_tuser     = head_q.user;
  assign m_tlast     = head_q.last;
  assign m_tvalid    = head_vld_q;
  assign err         = err_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_video_in_framer.sv
// Bench for video_in_framer: directed scenarios plus a random stream, checked
// against a beat-level frame model.
module tb_video_in_framer;
  localparam int LP = 4;
  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        reset, s_tvalid, s_tready, s_tuser, s_tlast;
  logic        m_tvalid, m_tready, m_tuser, m_tlast, enable, err_clr;
  logic [23:0] s_tdata, m_tdata;
  logic [2:0]  err;
  logic [15:0] frame_count;

  video_in_framer #(.LINE_PIXELS(LP), .FRAME_LINES(FL)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast),
    .enable(enable), .err_clr(err_clr), .err(err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
    int          c;
  } exp_t;

  exp_t        expq[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          stall_left = 0;
  bit          rand_ready = 0;
  bit          lat_chk = 0;
  bit          saw_full = 0;
  bit          acc_last = 0;
  // reference model state: in_frame flag, position of the next beat, status
  bit          mf_in;
  int          mf_pix, mf_line;
  logic [2:0]  mf_err;
  logic [15:0] mf_fc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    mf_in = 0; mf_pix = 0; mf_line = 0; mf_err = '0; mf_fc = '0;
  endtask

  // One accepted input beat, applied to the frame rules
  task automatic model_beat(logic [23:0] d, logic u, logic l);
    bit   keep = 0;
    exp_t e;
    e.u = 1'b0; e.l = 1'b0;
    if (!mf_in) begin
      if (u && enable) begin keep = 1; e.u = 1'b1; mf_in = 1; mf_pix = 0; mf_line = 0; end
    end else begin
      keep = 1;
      if (u) begin mf_err[2] = 1'b1; e.u = 1'b1; mf_pix = 0; mf_line = 0; end
    end
    if (keep) begin
      if (mf_pix == LP - 1) begin
        e.l = 1'b1;
        if (!l) begin mf_err[1] = 1'b1; mf_in = 0; end
        else if (mf_line == FL - 1) begin mf_fc = mf_fc + 16'd1; mf_in = 0; end
        else begin mf_pix = 0; mf_line++; end
      end else if (l) begin
        e.l = 1'b1; mf_err[0] = 1'b1; mf_in = 0;
      end else begin
        mf_pix++;
      end
      e.d = d; e.c = cyc;
      expq.push_back(e);
    end
  endtask

  // One clock: check output handshake, feed model, advance, check status
  task automatic step();
    exp_t e;
    acc_last = 0;
    if (stall_left > 0) begin m_tready = 1'b0; stall_left--; end
    else m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!reset) begin
      if (!s_tready) saw_full = 1;
      if (m_tvalid && m_tready) begin
        n_out++;
        if (expq.size() == 0) chk("unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
        else begin
          e = expq.pop_front();
          chk("m_tdata", 32'(m_tdata), 32'(e.d));
          chk("m_tuser", 32'(m_tuser), 32'(e.u));
          chk("m_tlast", 32'(m_tlast), 32'(e.l));
          if (lat_chk) chk("latency", 32'(cyc - e.c), 32'd1);
        end
      end
      if (err_clr) mf_err = '0;
      if (s_tvalid && s_tready) begin
        acc_last = 1;
        model_beat(s_tdata, s_tuser, s_tlast);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!reset) begin
      chk("err", 32'(err), 32'(mf_err));
      chk("frame_count", 32'(frame_count), 32'(mf_fc));
    end
  endtask

  task automatic send(logic [23:0] d, logic u, logic l);
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      step();
      if (acc_last) break;
    end
    if (!acc_last) chk("send_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (expq.size() == 0 && !m_tvalid) break;
      step();
    end
    chk("drain_empty", 32'(expq.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic send_frame();
    for (int b = 0; b < LP * FL; b++) send(24'($urandom), b == 0, (b % LP) == LP - 1);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
    chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
    chk({tag, "_m_tuser"}, 32'(m_tuser), 32'd0);
    chk({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_fc"}, 32'(frame_count), 32'd0);
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0; err_clr = 1'b0; stall_left = 0; reset = 1'b1;
    step();
    check_reset_outputs("rst");
    step();
    model_reset();
    reset = 1'b0;
    step();
    check_reset_outputs("rst_first");
    step();
    chk("rst_ready_back", 32'(s_tready), 32'd1);
  endtask

  initial begin
    s_tdata = '0; s_tuser = 0; s_tlast = 0; s_tvalid = 0;
    m_tready = 1; enable = 1; err_clr = 0; reset = 1;
    model_reset();
    @(negedge clk);
    do_reset();

    // clean frame, 1-cycle latency
    lat_chk = 1; n_out = 0;
    send_frame();
    drain();
    lat_chk = 0;
    chk("clean_beats", 32'(n_out), 32'd8);
    chk("clean_fc", 32'(frame_count), 32'd1);
    chk("clean_err", 32'(err), 32'd0);

    // backpressure mid-frame
    n_out = 0; saw_full = 0;
    for (int b = 0; b < 8; b++) begin
      if (b == 3) stall_left = 5;
      send(24'($urandom), b == 0, (b % LP) == LP - 1);
    end
    drain();
    chk("bp_saw_full", 32'(saw_full), 32'd1);
    chk("bp_beats", 32'(n_out), 32'd8);
    chk("bp_fc", 32'(frame_count), 32'd2);

    // short line then discarded beats
    n_out = 0;
    send(24'h111111, 1, 0); send(24'h222222, 0, 0); send(24'h333333, 0, 1);
    send(24'h444444, 0, 0); send(24'h555555, 0, 1);
    drain();
    chk("short_beats", 32'(n_out), 32'd3);
    chk("short_err", 32'(err), 32'd1);
    chk("short_fc", 32'(frame_count), 32'd2);

    // long line, then unexpected SOF restarting a frame
    pulse_clr();
    n_out = 0;
    for (int b = 0; b < 5; b++) send(24'($urandom), b == 0, 0);
    drain();
    chk("long_beats", 32'(n_out), 32'd4);
    chk("long_err", 32'(err), 32'd2);
    for (int b = 0; b < 5 + LP * FL; b++)
      send(24'($urandom), b == 0 || b == 5, (b == 3) || (b >= 5 && ((b - 5) % LP) == LP - 1));
    drain();
    chk("usof_err", 32'(err), 32'd6);
    chk("usof_fc", 32'(frame_count), 32'd3);

    // preamble, frame with enable low, then with enable high
    pulse_clr();
    n_out = 0;
    for (int b = 0; b < 3; b++) send(24'($urandom), 0, 0);
    enable = 0;
    send_frame();
    drain();
    chk("dis_beats", 32'(n_out), 32'd0);
    enable = 1;
    send_frame();
    drain();
    chk("en_beats", 32'(n_out), 32'd8);
    chk("en_fc", 32'(frame_count), 32'd4);

    // enable falling mid-frame does not truncate
    send(24'($urandom), 1, 0);
    enable = 0;
    for (int b = 1; b < 8; b++) send(24'($urandom), 0, (b % LP) == LP - 1);
    enable = 1;
    drain();
    chk("en_fall_fc", 32'(frame_count), 32'd5);

    // random stream with random backpressure and protocol faults
    rand_ready = 1;
    for (int i = 0, gp = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      else begin
        enable = ($urandom_range(0, 9) != 0);
        err_clr = ($urandom_range(0, 19) == 0);
        send(24'($urandom), (gp == 0) ^ ($urandom_range(0, 31) == 0),
             ((gp % LP) == LP - 1) ^ ($urandom_range(0, 15) == 0));
        err_clr = 0;
        gp = (gp + 1) % (LP * FL);
      end
    end
    rand_ready = 0; enable = 1;
    drain();

    // reset mid-line with FIFO occupied
    stall_left = 10;
    send(24'hABCDEF, 1, 0); send(24'h123456, 0, 0); send(24'h654321, 0, 0);
    do_reset();
    drain();

    // err_clr colliding with a short-line event
    for (int b = 0; b < 4; b++) send(24'($urandom), b == 0, 0);
    drain();
    chk("pre_collide_err", 32'(err), 32'd2);
    send(24'h0A0A0A, 1, 0);
    err_clr = 1;
    send(24'h0B0B0B, 0, 1);
    err_clr = 0;
    drain();
    chk("collide_err", 32'(err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
